// File: rtl/br_pkg.sv
// Shared types for the branch-commit unit.
//   - funct3 condition codes for conditional branches
//   - meta_slot_t  : per-instruction metadata carried through IF/ID and ID/EX
//   - commit_rec_t : resolved commit record held in the EX/MEM slot
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        btb_hit;
    logic        prediction;
    logic [31:0] btb_target;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
  } meta_slot_t;

  // pc_word is PC[31:2]; the low two bits are never needed after EX.
  typedef struct packed {
    logic        valid;
    logic [29:0] pc_word;
    logic [31:0] target;
    logic        btb_hit;
    logic        prediction;
    logic        decision;
    logic        is_jmp;
    logic [31:0] pc_plus4;
  } commit_rec_t;

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator (purely combinational).
//   funct3 : condition code (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   rs1    : first operand
//   rs2    : second operand
//   taken  : condition holds; reserved codes 010/011 resolve not-taken
module br_cond_eval
  import br_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;

  assign rs1_s = rs1;
  assign rs2_s = rs2;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = (rs1_s < rs2_s);
      F3_BGE:  taken = (rs1_s >= rs2_s);
      F3_BLTU: taken = (rs1 < rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_commit_unit.sv
// Branch-commit unit: carries prediction metadata IF -> ID -> EX, resolves
// branch condition and target in EX, and registers the commit record into
// the EX/MEM slot that drives the predictor update interface (EXMEM_*).
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   stall_i                  hold IF/ID, bubble into ID/EX
//   flush_i                  invalidate all three slots (wins over stall_i)
//   IF_*                     fetch PC and BTB/prediction metadata
//   ID_*                     decode bits for the instruction in IF/ID
//   EX_*                     forwarded operands and immediate for ID/EX
//   EXMEM_*                  registered commit record (indices, tag, target,
//                            hit, decision, is_jmp, prediction, PC+4)
// Optional feature (define BR_PERF_CNT_EN):
//   perf_br_cnt_o            saturating count of committed control transfers
//   perf_mispred_cnt_o       saturating count of commits whose prediction
//                            differs from the resolved decision
module branch_commit_unit
  import br_pkg::*;
#(
  parameter int PHT_INDEX_WIDTH = 8,
  parameter int BTB_INDEX_WIDTH = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic [31:0]                  IF_pc_i,
  input  logic                         IF_btb_hit_i,
  input  logic                         IF_prediction_i,
  input  logic [31:0]                  IF_btb_target_i,
  input  logic                         ID_is_br_i,
  input  logic                         ID_is_jal_i,
  input  logic                         ID_is_jalr_i,
  input  logic [2:0]                   ID_funct3_i,
  input  logic [31:0]                  EX_rs1_i,
  input  logic [31:0]                  EX_rs2_i,
  input  logic [31:0]                  EX_imm_i,
  output logic [BTB_INDEX_WIDTH-1:0]   EXMEM_btb_wr_index_o,
  output logic [PHT_INDEX_WIDTH-1:0]   EXMEM_pht_wr_index_o,
  output logic [29-BTB_INDEX_WIDTH:0]  EXMEM_btb_wr_tag_o,
  output logic [31:0]                  EXMEM_btb_wr_target_o,
  output logic                         EXMEM_btb_hit_o,
  output logic                         EXMEM_br_decision_o,
  output logic                         EXMEM_is_jmp_o,
  output logic                         EXMEM_prediction_o,
  output logic [31:0]                  EXMEM_PCplus4_o,
  output logic [31:0]                  EXMEM_br_target_o
`ifdef BR_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_br_cnt_o,
  output logic [31:0]                  perf_mispred_cnt_o
`endif
);

  meta_slot_t  slot_d0, slot_p0;
  meta_slot_t  slot_d1, slot_p1;
  commit_rec_t rec_d2, rec_p2;

  logic        cond_taken;
  logic [31:0] ex_target;
  logic        ex_decision;
  logic        ex_is_jmp;
  logic        target_miss;

  // ---- IF -> IF/ID ----
  always_comb begin
    slot_d0            = '0;
    slot_d0.valid      = 1'b1;
    slot_d0.pc         = IF_pc_i;
    slot_d0.btb_hit    = IF_btb_hit_i;
    slot_d0.prediction = IF_prediction_i;
    slot_d0.btb_target = IF_btb_target_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_p0 <= '0;
    end else if (flush_i) begin
      slot_p0 <= '0;
    end else if (!stall_i) begin
      slot_p0 <= slot_d0;
    end
  end

  // ---- ID -> ID/EX ----
  always_comb begin
    slot_d1         = slot_p0;
    slot_d1.is_br   = ID_is_br_i;
    slot_d1.is_jal  = ID_is_jal_i;
    slot_d1.is_jalr = ID_is_jalr_i;
    slot_d1.funct3  = ID_funct3_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_p1 <= '0;
    end else if (flush_i || stall_i) begin
      slot_p1 <= '0;
    end else begin
      slot_p1 <= slot_d1;
    end
  end

  // ---- EX resolution -> EX/MEM ----
  br_cond_eval u_cond_eval (
    .funct3 (slot_p1.funct3),
    .rs1    (EX_rs1_i),
    .rs2    (EX_rs2_i),
    .taken  (cond_taken)
  );

  assign ex_target   = slot_p1.is_jalr ? ((EX_rs1_i + EX_imm_i) & ~32'd1)
                                       : (slot_p1.pc + EX_imm_i);
  assign ex_is_jmp   = slot_p1.valid &
                       (slot_p1.is_br | slot_p1.is_jal | slot_p1.is_jalr);
  assign ex_decision = slot_p1.valid &
                       (slot_p1.is_jal | slot_p1.is_jalr | (slot_p1.is_br & cond_taken));
  // Predicted taken to the wrong place: report as a miss so the predictor
  // redirects to the resolved target and rewrites the BTB entry.
  assign target_miss = slot_p1.prediction & ex_decision &
                       (slot_p1.btb_target != ex_target);

  always_comb begin
    rec_d2            = '0;
    rec_d2.valid      = slot_p1.valid;
    rec_d2.pc_word    = slot_p1.pc[31:2];
    rec_d2.target     = ex_target;
    rec_d2.btb_hit    = slot_p1.btb_hit & ~target_miss;
    rec_d2.prediction = slot_p1.prediction & ~target_miss;
    rec_d2.decision   = ex_decision;
    rec_d2.is_jmp     = ex_is_jmp;
    rec_d2.pc_plus4   = slot_p1.pc + 32'd4;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rec_p2 <= '0;
    end else if (flush_i) begin
      rec_p2 <= '0;
    end else begin
      rec_p2 <= rec_d2;
    end
  end

  // ---- EX/MEM -> predictor ----
  assign EXMEM_btb_wr_index_o  = rec_p2.pc_word[BTB_INDEX_WIDTH-1:0];
  assign EXMEM_pht_wr_index_o  = rec_p2.pc_word[PHT_INDEX_WIDTH-1:0];
  assign EXMEM_btb_wr_tag_o    = rec_p2.pc_word[29:BTB_INDEX_WIDTH];
  assign EXMEM_btb_wr_target_o = rec_p2.target;
  assign EXMEM_br_target_o     = rec_p2.target;
  assign EXMEM_btb_hit_o       = rec_p2.btb_hit;
  assign EXMEM_prediction_o    = rec_p2.prediction;
  assign EXMEM_br_decision_o   = rec_p2.valid & rec_p2.decision;
  assign EXMEM_is_jmp_o        = rec_p2.valid & rec_p2.is_jmp;
  assign EXMEM_PCplus4_o       = rec_p2.pc_plus4;

`ifdef BR_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_br_cnt_o      <= '0;
      perf_mispred_cnt_o <= '0;
    end else if (EXMEM_is_jmp_o) begin
      perf_br_cnt_o <= sat_inc(perf_br_cnt_o);
      if (EXMEM_prediction_o != EXMEM_br_decision_o) begin
        perf_mispred_cnt_o <= sat_inc(perf_mispred_cnt_o);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_commit_unit.sv
`timescale 1ns/1ps
module tb_branch_commit_unit;

  localparam int PHT_W   = 8;
  localparam int BTB_W   = 6;
  localparam int K_OTHER = 0;
  localparam int K_BR    = 1;
  localparam int K_JAL   = 2;
  localparam int K_JALR  = 3;

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        pred;
    logic [31:0] btb_tgt;
    int          kind;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
  } instr_t;

  typedef struct {
    logic             is_jmp;
    logic             dec;
    logic             pred;
    logic             hit;
    logic [31:0]      tgt;
    logic [31:0]      pc4;
    logic [BTB_W-1:0] bidx;
    logic [PHT_W-1:0] pidx;
    logic [29-BTB_W:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni, stall_i, flush_i;
  logic [31:0] IF_pc_i, IF_btb_target_i;
  logic IF_btb_hit_i, IF_prediction_i;
  logic ID_is_br_i, ID_is_jal_i, ID_is_jalr_i;
  logic [2:0] ID_funct3_i;
  logic [31:0] EX_rs1_i, EX_rs2_i, EX_imm_i;
  logic [BTB_W-1:0] EXMEM_btb_wr_index_o;
  logic [PHT_W-1:0] EXMEM_pht_wr_index_o;
  logic [29-BTB_W:0] EXMEM_btb_wr_tag_o;
  logic [31:0] EXMEM_btb_wr_target_o, EXMEM_PCplus4_o, EXMEM_br_target_o;
  logic EXMEM_btb_hit_o, EXMEM_br_decision_o, EXMEM_is_jmp_o, EXMEM_prediction_o;
`ifdef BR_PERF_CNT_EN
  logic [31:0] perf_br_cnt_o, perf_mispred_cnt_o;
  int exp_br = 0;
  int exp_mis = 0;
`endif

  branch_commit_unit #(.PHT_INDEX_WIDTH(PHT_W), .BTB_INDEX_WIDTH(BTB_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall_i), .flush_i(flush_i),
    .IF_pc_i(IF_pc_i), .IF_btb_hit_i(IF_btb_hit_i), .IF_prediction_i(IF_prediction_i),
    .IF_btb_target_i(IF_btb_target_i),
    .ID_is_br_i(ID_is_br_i), .ID_is_jal_i(ID_is_jal_i), .ID_is_jalr_i(ID_is_jalr_i),
    .ID_funct3_i(ID_funct3_i),
    .EX_rs1_i(EX_rs1_i), .EX_rs2_i(EX_rs2_i), .EX_imm_i(EX_imm_i),
    .EXMEM_btb_wr_index_o(EXMEM_btb_wr_index_o), .EXMEM_pht_wr_index_o(EXMEM_pht_wr_index_o),
    .EXMEM_btb_wr_tag_o(EXMEM_btb_wr_tag_o), .EXMEM_btb_wr_target_o(EXMEM_btb_wr_target_o),
    .EXMEM_btb_hit_o(EXMEM_btb_hit_o), .EXMEM_br_decision_o(EXMEM_br_decision_o),
    .EXMEM_is_jmp_o(EXMEM_is_jmp_o), .EXMEM_prediction_o(EXMEM_prediction_o),
    .EXMEM_PCplus4_o(EXMEM_PCplus4_o), .EXMEM_br_target_o(EXMEM_br_target_o)
`ifdef BR_PERF_CNT_EN
    , .perf_br_cnt_o(perf_br_cnt_o), .perf_mispred_cnt_o(perf_mispred_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  instr_t tbl[2048];
  instr_t pending[$];
  int nf      = 0;
  int id_idx  = -1;
  int ex_idx  = -1;
  int mem_idx = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // What the predictor should see for a committing instruction.
  function automatic exp_t model(input instr_t i);
    exp_t e;
    logic miss;
    e.is_jmp = (i.kind != K_OTHER);
    e.dec    = (i.kind == K_BR) ? cond(i.f3, i.rs1, i.rs2) : (i.kind != K_OTHER);
    e.tgt    = (i.kind == K_JALR) ? ((i.rs1 + i.imm) & 32'hFFFF_FFFE) : (i.pc + i.imm);
    miss     = i.pred && e.dec && (i.btb_tgt != e.tgt);
    e.pred   = i.pred && !miss;
    e.hit    = i.hit && !miss;
    e.pc4    = i.pc + 32'd4;
    e.bidx   = i.pc[BTB_W+1:2];
    e.pidx   = i.pc[PHT_W+1:2];
    e.tag    = i.pc[31:BTB_W+2];
    return e;
  endfunction

  function automatic instr_t mk(input logic [31:0] pc, input logic hit, input logic pred,
                                input logic [31:0] tgt, input int kind, input logic [2:0] f3,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm);
    instr_t i;
    i.pc = pc; i.hit = hit; i.pred = pred; i.btb_tgt = tgt; i.kind = kind;
    i.f3 = f3; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    i.pc   = $urandom;
    i.hit  = 1'($urandom_range(0, 1));
    i.pred = 1'($urandom_range(0, 1));
    i.kind = int'($urandom_range(0, 3));
    i.f3   = 3'($urandom_range(0, 7));
    i.rs1  = $urandom;
    i.rs2  = ($urandom_range(0, 2) == 0) ? i.rs1 : $urandom;
    i.imm  = $urandom;
    case ($urandom_range(0, 2))
      0:       i.btb_tgt = i.pc + i.imm;
      1:       i.btb_tgt = (i.rs1 + i.imm) & 32'hFFFF_FFFE;
      default: i.btb_tgt = $urandom;
    endcase
    return i;
  endfunction

  task automatic check_commit();
    exp_t e;
`ifdef BR_PERF_CNT_EN
    chk("perf_br_cnt", perf_br_cnt_o, 32'(exp_br));
    chk("perf_mispred_cnt", perf_mispred_cnt_o, 32'(exp_mis));
`endif
    if (mem_idx < 0) begin
      chk("idle_is_jmp", 32'(EXMEM_is_jmp_o), 32'd0);
      chk("idle_decision", 32'(EXMEM_br_decision_o), 32'd0);
    end else begin
      e = model(tbl[mem_idx]);
      chk("is_jmp", 32'(EXMEM_is_jmp_o), 32'(e.is_jmp));
      chk("decision", 32'(EXMEM_br_decision_o), 32'(e.dec));
      chk("prediction", 32'(EXMEM_prediction_o), 32'(e.pred));
      chk("btb_hit", 32'(EXMEM_btb_hit_o), 32'(e.hit));
      chk("pcplus4", EXMEM_PCplus4_o, e.pc4);
      chk("btb_index", 32'(EXMEM_btb_wr_index_o), 32'(e.bidx));
      chk("pht_index", 32'(EXMEM_pht_wr_index_o), 32'(e.pidx));
      chk("btb_tag", 32'(EXMEM_btb_wr_tag_o), 32'(e.tag));
      if (e.is_jmp) begin
        chk("br_target", EXMEM_br_target_o, e.tgt);
        chk("btb_wr_target", EXMEM_btb_wr_target_o, e.tgt);
      end
`ifdef BR_PERF_CNT_EN
      if (e.is_jmp) begin
        exp_br++;
        if (e.pred != e.dec) exp_mis++;
      end
`endif
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_btb_index"}, 32'(EXMEM_btb_wr_index_o), 32'd0);
    chk({tag, "_pht_index"}, 32'(EXMEM_pht_wr_index_o), 32'd0);
    chk({tag, "_btb_tag"}, 32'(EXMEM_btb_wr_tag_o), 32'd0);
    chk({tag, "_btb_target"}, EXMEM_btb_wr_target_o, 32'd0);
    chk({tag, "_flags"}, 32'({EXMEM_btb_hit_o, EXMEM_br_decision_o,
                              EXMEM_is_jmp_o, EXMEM_prediction_o}), 32'd0);
    chk({tag, "_pcplus4"}, EXMEM_PCplus4_o, 32'd0);
    chk({tag, "_br_target"}, EXMEM_br_target_o, 32'd0);
`ifdef BR_PERF_CNT_EN
    chk({tag, "_perf_br"}, perf_br_cnt_o, 32'd0);
    chk({tag, "_perf_mis"}, perf_mispred_cnt_o, 32'd0);
`endif
  endtask

  // One clock: check the commit, drive all stages, advance the stage model.
  task automatic cycle(input logic st, input logic fl);
    instr_t f, d, x;
    int fi;
    check_commit();
    fi = -1;
    if (!st && !fl) begin
      if (pending.size() > 0) f = pending.pop_front();
      else f = rnd_instr();
      tbl[nf] = f;
      fi = nf;
      nf++;
    end else begin
      f = rnd_instr();
    end
    IF_pc_i = f.pc; IF_btb_hit_i = f.hit; IF_prediction_i = f.pred; IF_btb_target_i = f.btb_tgt;
    d = (id_idx >= 0) ? tbl[id_idx] : rnd_instr();
    ID_is_br_i = (d.kind == K_BR); ID_is_jal_i = (d.kind == K_JAL);
    ID_is_jalr_i = (d.kind == K_JALR); ID_funct3_i = d.f3;
    x = (ex_idx >= 0) ? tbl[ex_idx] : rnd_instr();
    EX_rs1_i = x.rs1; EX_rs2_i = x.rs2; EX_imm_i = x.imm;
    stall_i = st; flush_i = fl;
    @(posedge clk);
    if (fl) begin
      id_idx = -1; ex_idx = -1; mem_idx = -1;
    end else begin
      mem_idx = ex_idx;
      ex_idx  = st ? -1 : id_idx;
      if (!st) id_idx = fi;
    end
    @(negedge clk);
    stall_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic model_reset();
    id_idx = -1; ex_idx = -1; mem_idx = -1;
`ifdef BR_PERF_CNT_EN
    exp_br = 0; exp_mis = 0;
`endif
  endtask

  initial begin
    rst_ni = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    IF_pc_i = '0; IF_btb_hit_i = 1'b0; IF_prediction_i = 1'b0; IF_btb_target_i = '0;
    ID_is_br_i = 1'b0; ID_is_jal_i = 1'b0; ID_is_jalr_i = 1'b0; ID_funct3_i = '0;
    EX_rs1_i = '0; EX_rs2_i = '0; EX_imm_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_ni = 1'b1;
    model_reset();

    // BEQ taken, predicted not-taken
    pending.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0, K_BR, 3'b000, 32'd5, 32'd5, 32'h20));
    repeat (3) cycle(1'b0, 1'b0);
    chk("beq_is_jmp", 32'(EXMEM_is_jmp_o), 32'd1);
    chk("beq_decision", 32'(EXMEM_br_decision_o), 32'd1);
    chk("beq_prediction", 32'(EXMEM_prediction_o), 32'd0);
    chk("beq_target", EXMEM_br_target_o, 32'h120);
    chk("beq_pcplus4", EXMEM_PCplus4_o, 32'h104);

    // BLTU vs BLT on the same operands
    pending.push_back(mk(32'h200, 1'b0, 1'b0, 32'h0, K_BR, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h8));
    pending.push_back(mk(32'h204, 1'b0, 1'b0, 32'h0, K_BR, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h8));
    repeat (3) cycle(1'b0, 1'b0);
    chk("bltu_decision", 32'(EXMEM_br_decision_o), 32'd0);
    cycle(1'b0, 1'b0);
    chk("blt_decision", 32'(EXMEM_br_decision_o), 32'd1);

    // JALR predicted to a stale target
    pending.push_back(mk(32'h300, 1'b1, 1'b1, 32'h3000, K_JALR, 3'b000, 32'h2001, 32'h0, 32'h4));
    repeat (3) cycle(1'b0, 1'b0);
    chk("jalr_target", EXMEM_br_target_o, 32'h2004);
    chk("jalr_prediction", 32'(EXMEM_prediction_o), 32'd0);
    chk("jalr_btb_hit", 32'(EXMEM_btb_hit_o), 32'd0);
    chk("jalr_decision", 32'(EXMEM_br_decision_o), 32'd1);

    // Correctly predicted taken branch keeps its prediction and hit
    pending.push_back(mk(32'h400, 1'b1, 1'b1, 32'h440, K_BR, 3'b001, 32'd1, 32'd2, 32'h40));
    repeat (3) cycle(1'b0, 1'b0);
    chk("bne_ok_prediction", 32'(EXMEM_prediction_o), 32'd1);
    chk("bne_ok_btb_hit", 32'(EXMEM_btb_hit_o), 32'd1);

    // Reset while a BEQ sits in ID/EX
    pending.push_back(mk(32'h180, 1'b0, 1'b0, 32'h0, K_BR, 3'b000, 32'd7, 32'd7, 32'h10));
    repeat (2) cycle(1'b0, 1'b0);
    rst_ni = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("midrst");
    rst_ni = 1'b1;
    model_reset();
    repeat (4) cycle(1'b0, 1'b0);

    // Flush with three branches in flight, then a fresh branch
    for (int k = 0; k < 3; k++)
      pending.push_back(mk(32'h600 + 32'(4 * k), 1'b0, 1'b1, 32'h0, K_BR, 3'b000,
                           32'd1, 32'd1, 32'h100));
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    chk("flush_is_jmp", 32'(EXMEM_is_jmp_o), 32'd0);
    pending.push_back(mk(32'h700, 1'b0, 1'b0, 32'h0, K_BR, 3'b000, 32'd3, 32'd3, 32'h8));
    repeat (5) cycle(1'b0, 1'b0);

    // Two-cycle stall with a BNE in IF/ID
    pending.push_back(mk(32'h500, 1'b0, 1'b0, 32'h0, K_BR, 3'b001, 32'd3, 32'd4, 32'h10));
    cycle(1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);

    // Randomized traffic with stalls and flushes (sometimes together)
    repeat (500) cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    repeat (4) cycle(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
